// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory access unit (master) and the data memory (slave).
// Valid/ready request channel plus a single-beat response channel.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              dbus_req_valid;
    logic              dbus_req_ready;
    logic              dbus_req_we;
    logic [ADDR_W-1:0] dbus_req_addr;
    logic [DATA_W-1:0] dbus_req_wdata;
    logic [7:0]        dbus_req_wstrb;
    logic              dbus_resp_valid;
    logic [DATA_W-1:0] dbus_resp_rdata;

    modport master (
        output dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
        input  dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
    );

    modport slave (
        input  dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
        output dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: launches one aligned load/store per ME instruction on the data bus,
// stalls the pipeline until it completes, and returns the extended load result.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              me_mem_rena,
    input  logic              me_mem_wena,
    input  logic              me_mem_ext_un,
    input  logic [7:0]        me_mem_byte_enable,
    input  logic [ADDR_W-1:0] me_alu_result,
    input  logic [DATA_W-1:0] me_new_rs2_data,
    mem_access_unit_if.master dbus,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall_req,
    output logic              mem_misalign
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [2:0]        off_q;
    logic [3:0]        size_q;
    logic              ext_un_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;

    logic              acc;
    logic [2:0]        off;
    logic [3:0]        size;
    logic              mis;
    logic              launch;
    logic              capture;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_val;

    assign acc = me_mem_rena | me_mem_wena;
    assign off = me_alu_result[2:0];

    always_comb begin
        if (me_mem_byte_enable[7]) begin
            size = 4'd8;
        end else if (me_mem_byte_enable[3]) begin
            size = 4'd4;
        end else if (me_mem_byte_enable[1]) begin
            size = 4'd2;
        end else begin
            size = 4'd1;
        end
    end

    assign mis = ({1'b0, off} + size) > 4'd8;

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (acc && !mis) begin
                    launch  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (dbus.dbus_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dbus.dbus_resp_valid) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bring the addressed bytes down to lane 0, then extend from the top byte of the access size.
    always_comb begin
        shifted = dbus.dbus_resp_rdata >> {off_q, 3'b000};
        case (size_q)
            4'd1:    load_val = {{(DATA_W-8){~ext_un_q & shifted[7]}}, shifted[7:0]};
            4'd2:    load_val = {{(DATA_W-16){~ext_un_q & shifted[15]}}, shifted[15:0]};
            4'd4:    load_val = {{(DATA_W-32){~ext_un_q & shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            off_q    <= '0;
            size_q   <= '0;
            ext_un_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                we_q     <= me_mem_wena;
                off_q    <= off;
                size_q   <= size;
                ext_un_q <= me_mem_ext_un;
                addr_q   <= {me_alu_result[ADDR_W-1:3], 3'b000};
                wdata_q  <= me_new_rs2_data << {off, 3'b000};
                wstrb_q  <= me_mem_byte_enable << off;
            end
            if (capture) begin
                rdata_q <= we_q ? '0 : load_val;
            end
        end
    end

    assign dbus.dbus_req_valid = (state_q == StReq);
    assign dbus.dbus_req_we    = we_q;
    assign dbus.dbus_req_addr  = addr_q;
    assign dbus.dbus_req_wdata = wdata_q;
    assign dbus.dbus_req_wstrb = wstrb_q;

    assign mem_rdata     = rdata_q;
    assign mem_done      = (state_q == StDone);
    assign mem_misalign  = (state_q == StIdle) & acc & mis;
    assign mem_stall_req = ((state_q == StIdle) & acc & !mis) | (state_q == StReq)
                         | (state_q == StWait);
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access engine. Consumes the ME-stage load/store controls held in the EX/ME pipeline register and performs the transfer on a valid/ready data bus.
- Aligns store data and strobes to 64-bit lanes, and extracts and extends load data.
- Raises a stall request that holds the pipeline until the access completes.
- Sits between the EX/ME register outputs, the hazard/stall controller and the data-memory port.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data-bus width; the lane logic is fixed to 8 byte lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- me_mem_rena  in  1  load request from ME stage.
- me_mem_wena  in  1  store request from ME stage.
- me_mem_ext_un  in  1  1 = zero-extend load, 0 = sign-extend.
- me_mem_byte_enable  in  8  right-aligned size mask: 0x01 byte, 0x03 half, 0x0F word, 0xFF dword.
- me_alu_result  in  64  effective byte address.
- me_new_rs2_data  in  64  store data, right-aligned.
- dbus_req_valid  out  1  bus request valid.
- dbus_req_ready  in  1  bus accepts the request.
- dbus_req_we  out  1  1 = write.
- dbus_req_addr  out  64  address with bits [2:0] forced to 0.
- dbus_req_wdata  out  64  lane-shifted store data.
- dbus_req_wstrb  out  8  lane-shifted byte strobes.
- dbus_resp_valid  in  1  read data / write ack.
- dbus_resp_rdata  in  64  raw 64-bit read data.
- mem_rdata  out  64  extended load result, valid while mem_done = 1.
- mem_done  out  1  one-cycle completion pulse.
- mem_stall_req  out  1  hold request to the stall controller.
- mem_misalign  out  1  access crosses an 8-byte boundary.

Behaviour:
- Reset (async, rst = 0): state = IDLE. All registered outputs are 0: dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb, mem_rdata, mem_done.
- Access present: acc = me_mem_rena | me_mem_wena. If both are set, treat as a store.
- Size: be[7] → 8, else be[3] → 4, else be[1] → 2, else 1. off = addr[2:0]. mis = off + size > 8.
- mem_misalign (combinational) = (state == IDLE) & acc & mis. A misaligned access produces no bus activity and no stall; trap handling belongs elsewhere.
- mem_stall_req (combinational) = (IDLE & acc & !mis) | REQ | WAIT_RESP. It is low in DONE.
- IDLE:
  - On acc & !mis, latch we, off, size, ext_un, the aligned address, wdata = rs2 << (8*off), and wstrb = be << off. Go to REQ.
- REQ:
  - dbus_req_valid = 1. All request fields stay stable until accepted.
  - On dbus_req_ready, go to WAIT_RESP and drop valid on the next cycle.
- WAIT_RESP:
  - On dbus_resp_valid, go to DONE.
  - For a load, register mem_rdata = ext((rdata >> 8*off) masked to size bytes). ext is zero-extension if ext_un = 1, otherwise sign-extension from the top byte of the size.
  - For a store, mem_rdata = 0.
- DONE:
  - mem_done = 1 for exactly one cycle, then go to IDLE.
  - The ME register still holds the same instruction during DONE. DONE never re-launches it, and the pipeline advances at the end of DONE.
- dbus_resp_valid outside WAIT_RESP is ignored. A response never arrives in the same cycle the request is accepted.
- Minimum latency, from access first visible in ME (cycle 0):
  - cycle 1: req_valid.
  - cycle 1: ready → WAIT_RESP at cycle 2.
  - cycle 2: resp_valid → DONE at cycle 3.
  - Stall is asserted for cycles 0–2; mem_done at cycle 3.
- Back-pressure: dbus_req_ready = 0 holds REQ indefinitely with all request fields unchanged.
- Reset mid-access: immediate return to IDLE and valid drops asynchronously. Any late response after reset is ignored.
- Bubbles from the EX/ME register (rena = wena = 0) keep the block in IDLE with stall low.

Test Plan:
- Signed load byte:
  - Stimulus: rena, be 0x01, addr 0x8000_0003, ext_un 0; ready at cycle 1; resp at cycle 2 with rdata 0x0000_0000_8000_0000.
  - Required: req_addr 0x8000_0000; stall high for cycles 0–2; mem_done and mem_rdata 0xFFFF_FFFF_FFFF_FF80 at cycle 3.
- Unsigned load byte: same stimulus with ext_un 1 → mem_rdata 0x0000_0000_0000_0080.
- Store half:
  - Stimulus: wena, be 0x03, addr 0x8000_0006, rs2 0x1234_BEEF.
  - Required: req_we 1, req_addr 0x8000_0000, wstrb 0xC0, wdata 0xBEEF_0000_0000_0000; mem_rdata 0 at done.
- Back-pressure: ready held low for 5 cycles → req_valid and all fields stable for 5 cycles; stall high throughout; completes normally afterwards.
- Misaligned word:
  - Stimulus: rena, be 0x0F, addr 0x8000_0006.
  - Required: mem_misalign 1, req_valid never asserted, stall 0.
- Reset mid-access: rst low during WAIT_RESP, then resp_valid pulses → state IDLE, all outputs 0, no mem_done.
